// File: rtl/tx_console_rx_pkg.sv
// Shared console framing symbols and receiver state encoding.
package InstructionStruct;

    localparam logic [6:0] IDLE_SYM  = 7'h7F;
    localparam logic [6:0] START_SYM = 7'h00;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        ARMED,
        DATA
    } console_rx_state_t;

endpackage

// File: rtl/tx_console_rx_if.sv
// Character stream handshake: producer presents {last, data} under valid, consumer answers with ready.
interface tx_console_rx_if #(
    parameter int CWIDTH = 7
);
    logic [CWIDTH-1:0] char_data;
    logic              char_last;
    logic              char_valid;
    logic              char_ready;

    modport master (output char_data, output char_last, output char_valid, input char_ready);
    modport slave  (input char_data, input char_last, input char_valid, output char_ready);
endinterface

// File: rtl/tx_console_rx_char_fifo.sv
// Synchronous FIFO for {last, char} entries. A push into a full buffer is
// accepted only when a pop frees the head slot in the same cycle.
module char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               rd_ptr;
    logic [AW-1:0]               wr_ptr;
    logic [AW:0]                 count;
    logic                        do_push;
    logic                        do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    // Head is masked while empty so the output reads zero out of reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; when full with a pop, wr_ptr == rd_ptr and the slot being freed is reused.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/tx_console_rx.sv
// Console stream receiver: frames the CPU's tx symbols into messages and
// buffers characters with an end-of-message flag for a valid/ready consumer.
module tx_console_rx
    import InstructionStruct::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CWIDTH     = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CWIDTH-1:0] rx,
    tx_console_rx_if.master   chr,
    output logic [15:0]       msg_count,
    output logic              overflow,
    output logic              frame_err,
    input  logic              clr_err,
    output logic              busy
);
    console_rx_state_t state, state_nx;

    logic [CWIDTH-1:0] staged;
    logic              stage_ld;
    logic              push_req;
    logic              push_last;
    logic              frame_set;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              drop;
    logic [CWIDTH:0]   fifo_dout;

    assign fifo_pop       = chr.char_valid & chr.char_ready;
    assign drop           = push_req & fifo_full & ~fifo_pop;
    assign chr.char_valid = ~fifo_empty;
    assign chr.char_last  = fifo_dout[CWIDTH];
    assign chr.char_data  = fifo_dout[CWIDTH-1:0];
    assign busy           = (state == ARMED) || (state == DATA);

    char_fifo #(
        .WIDTH (CWIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .din   ({push_last, staged}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Framing state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= SYNC;
        else       state <= state_nx;
    end

    // Framing decode: the staged character is pushed once the following symbol reveals whether it ends the message.
    always_comb begin
        state_nx  = state;
        push_req  = 1'b0;
        push_last = 1'b0;
        stage_ld  = 1'b0;
        frame_set = 1'b0;
        case (state)
            SYNC: begin
                if (rx == IDLE_SYM) state_nx = IDLE;
            end
            IDLE: begin
                if (rx == START_SYM) state_nx = ARMED;
            end
            ARMED: begin
                if (rx == IDLE_SYM) begin
                    state_nx = IDLE;
                end else if (rx != START_SYM) begin
                    stage_ld = 1'b1;
                    state_nx = DATA;
                end
            end
            DATA: begin
                push_req = 1'b1;
                if (rx == IDLE_SYM) begin
                    push_last = 1'b1;
                    state_nx  = IDLE;
                end else if (rx == START_SYM) begin
                    push_last = 1'b1;
                    frame_set = 1'b1;
                    state_nx  = ARMED;
                end else begin
                    stage_ld = 1'b1;
                end
            end
            default: state_nx = SYNC;
        endcase
    end

    // One-entry staging register holding the character whose "last" status is not yet known.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         staged <= '0;
        else if (stage_ld) staged <= rx;
    end

    // Message counter and sticky error flags; a new error outranks a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg_count <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push_req && push_last) msg_count <= msg_count + 16'd1;
            overflow  <= (overflow  & ~clr_err) | drop;
            frame_err <= (frame_err & ~clr_err) | frame_set;
        end
    end
endmodule

// File: tb/tb_tx_console_rx.sv
// Scoreboard bench for tx_console_rx: stimulus pushes expected {last,char}
// entries, a negedge monitor pops and compares every accepted output.
module tb_tx_console_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  rx;
    logic        clr_err;
    logic [15:0] msg_count;
    logic        overflow;
    logic        frame_err;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic        busy_en = 1'b0;
    int          busy_cnt = 0;

    tx_console_rx_if #(.CWIDTH(7)) cif ();

    tx_console_rx #(.FIFO_DEPTH(16), .CWIDTH(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .chr       (cif),
        .msg_count (msg_count),
        .overflow  (overflow),
        .frame_err (frame_err),
        .clr_err   (clr_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake seen here is popped by the DUT on the next rising edge.
    always @(negedge clk) begin
        if (reset === 1'b0 && cif.char_valid === 1'b1 && cif.char_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_entry: got %0h expected none", {cif.char_last, cif.char_data});
            end else begin
                check("entry", int'({cif.char_last, cif.char_data}), int'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (busy_en && busy) busy_cnt++;
    end

    task automatic send(input logic [6:0] sym);
        @(posedge clk);
        #1 rx = sym;
    endtask

    task automatic expect_entry(input logic last, input logic [6:0] ch);
        exp_q.push_back({last, ch});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        check(name, exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset          = 1'b1;
        rx             = 7'h00;
        clr_err        = 1'b0;
        cif.char_ready = 1'b0;

        // Reset values
        #12;
        check("rst_valid", int'(cif.char_valid), 0);
        check("rst_data", int'(cif.char_data), 0);
        check("rst_last", int'(cif.char_last), 0);
        check("rst_msgs", int'(msg_count), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk) reset = 1'b0;

        // Post-reset zero held: ignored until IDLE_SYM
        cif.char_ready = 1'b1;
        repeat (5) send(7'h00);
        send(7'h41);
        send(7'h7F);
        send(7'h7F);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sync_valid", int'(cif.char_valid), 0);
        check("sync_msgs", int'(msg_count), 0);
        check("sync_busy", int'(busy), 0);

        // Basic message "Hi"
        expect_entry(1'b0, 7'h48);
        expect_entry(1'b1, 7'h69);
        send(7'h7F); send(7'h7F); send(7'h00); send(7'h48); send(7'h69); send(7'h7F);
        drain("basic_drain");
        check("basic_msgs", int'(msg_count), 1);
        check("basic_ovf", int'(overflow), 0);
        check("basic_ferr", int'(frame_err), 0);

        // Empty message with stretched start
        busy_cnt = 0;
        busy_en  = 1'b1;
        send(7'h7F); send(7'h00); send(7'h00); send(7'h7F); send(7'h7F);
        repeat (3) @(posedge clk);
        @(negedge clk);
        busy_en = 1'b0;
        check("empty_busy_cycles", busy_cnt, 2);
        check("empty_msgs", int'(msg_count), 1);
        check("empty_valid", int'(cif.char_valid), 0);

        // Frame error: start inside a message
        expect_entry(1'b0, 7'h41);
        expect_entry(1'b1, 7'h42);
        expect_entry(1'b1, 7'h43);
        send(7'h7F); send(7'h00); send(7'h41); send(7'h42); send(7'h00); send(7'h43); send(7'h7F);
        drain("ferr_drain");
        check("ferr_msgs", int'(msg_count), 3);
        check("ferr_flag", int'(frame_err), 1);
        check("ferr_ovf", int'(overflow), 0);
        pulse_clr();
        check("ferr_clr", int'(frame_err), 0);

        // Overflow: 20 characters into a stalled 16-entry buffer
        cif.char_ready = 1'b0;
        send(7'h00);
        for (int i = 0; i < 20; i++) send(7'(8'h41 + i));
        send(7'h7F);
        send(7'h7F);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ovf_flag", int'(overflow), 1);
        check("ovf_msgs", int'(msg_count), 4);
        check("ovf_head", int'(cif.char_data), 'h41);
        check("ovf_ferr", int'(frame_err), 0);
        pulse_clr();
        check("ovf_clr", int'(overflow), 0);
        for (int i = 0; i < 16; i++) expect_entry(1'b0, 7'(8'h41 + i));
        cif.char_ready = 1'b1;
        drain("ovf_drain");
        check("ovf_empty", int'(cif.char_valid), 0);

        // Asynchronous reset between 'B' and 'C'
        cif.char_ready = 1'b0;
        send(7'h7F); send(7'h00); send(7'h41); send(7'h42);
        @(posedge clk);
        #1;
        check("mid_prereset_valid", int'(cif.char_valid), 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", int'(cif.char_valid), 0);
        check("mid_rst_data", int'(cif.char_data), 0);
        check("mid_rst_msgs", int'(msg_count), 0);
        check("mid_rst_busy", int'(busy), 0);
        @(negedge clk) reset = 1'b0;
        cif.char_ready = 1'b1;
        expect_entry(1'b1, 7'h5A);
        send(7'h43); send(7'h44); send(7'h7F); send(7'h00); send(7'h5A); send(7'h7F);
        drain("mid_drain");
        check("mid_msgs", int'(msg_count), 1);
        check("mid_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
